imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 103 ++++++++++
 tb/tb_imem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one synchronous memory port between the
// program loader and the fetch stage, and tracks halt, fault and fetch count.
module imem_arbiter #(
  parameter int          MEM_WORDS = 10000,
  parameter logic [31:0] HALT_WORD = 32'hB4221820,
  parameter logic [31:0] NOP_WORD  = 32'h00000020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_done,
  output logic        ld_gnt,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  state_t state_q, state_d;
  logic   bad_q;
  logic   if_bad;
  logic   hit_halt;

  assign state = state_q;

  assign if_bad = (if_addr[1:0] != 2'b00) || ((if_addr >> 2) >= MEM_LIMIT);

  // The memory answers one cycle after the grant, so the returned word is
  // selected from registered flags; nothing is presented while if_valid is low.
  assign if_inst  = if_valid ? (bad_q ? NOP_WORD : mem_rdata) : 32'h0;
  assign hit_halt = if_valid && (if_inst == HALT_WORD);

  always_comb begin
    ld_gnt    = 1'b0;
    if_gnt    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = ld_data;
    state_d   = state_q;
    case (state_q)
      LOAD: begin
        ld_gnt   = ld_req;
        mem_we   = ld_req;
        mem_addr = ld_addr >> 2;
        if (ld_done) state_d = RUN;
      end
      RUN: begin
        // Loader wins the port; the fetch stalls for that cycle.
        if (ld_req) begin
          ld_gnt   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = ld_addr >> 2;
        end else if (if_req) begin
          if_gnt   = 1'b1;
          mem_addr = if_addr >> 2;
        end
        if (hit_halt) state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      if_valid  <= 1'b0;
      bad_q     <= 1'b0;
      halted    <= 1'b0;
      fault     <= 1'b0;
      fetch_cnt <= 16'h0;
    end else begin
      state_q  <= state_d;
      if_valid <= if_gnt;
      if (if_gnt) bad_q <= if_bad;
      if (if_gnt && if_bad) fault <= 1'b1;
      // Counted as the delivery is launched, so the count already includes the
      // word on if_valid in the following cycle.
      if (if_gnt && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
      if ((state_q == RUN) && hit_halt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table of per-cycle vectors, a fetch-data scoreboard,
// and hand-written reset, in-flight and saturation sequences.
module tb_imem_arbiter;

  localparam logic [31:0] HALT = 32'hB4221820;
  localparam logic [31:0] NOP  = 32'h00000020;
  localparam logic [31:0] W0   = 32'hAAAA0001;
  localparam logic [31:0] W1   = 32'h12345678;
  localparam logic [31:0] W2   = 32'h20100000;
  localparam logic [1:0]  S_LOAD = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_req = 1'b0, ld_done = 1'b0, if_req = 1'b0;
  logic [31:0] ld_addr = 32'h0, ld_data = 32'h0, if_addr = 32'h0;
  logic        ld_gnt, if_gnt, if_valid, mem_we, halted, fault;
  logic [31:0] if_inst, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [15:0] fetch_cnt;
  logic [1:0]  state;

  imem_arbiter dut (
    .clk(clk), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done),
    .ld_gnt(ld_gnt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_valid(if_valid), .if_inst(if_inst),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .halted(halted), .fault(fault), .fetch_cnt(fetch_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Synchronous memory fixture: read data one cycle after the address.
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[5:0]];
  end

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] img [0:63];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        if_req;
    logic [31:0] if_addr;
    logic        e_ld_gnt;
    logic        e_if_gnt;
    logic        e_we;
    logic [31:0] e_maddr;
    logic [1:0]  e_state;
    logic        e_halted;
    logic        e_fault;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic lr, input logic [31:0] la, input logic [31:0] ld,
                              input logic dn, input logic ir, input logic [31:0] ia,
                              input logic lg, input logic ig, input logic we,
                              input logic [31:0] ma, input logic [1:0] st,
                              input logic h, input logic f, input logic [15:0] c);
    vec_t v;
    v.ld_req = lr; v.ld_addr = la; v.ld_data = ld; v.ld_done = dn;
    v.if_req = ir; v.if_addr = ia;
    v.e_ld_gnt = lg; v.e_if_gnt = ig; v.e_we = we; v.e_maddr = ma;
    v.e_state = st; v.e_halted = h; v.e_fault = f; v.e_cnt = c;
    return v;
  endfunction

  function automatic logic [31:0] expect_inst(input logic [31:0] a);
    if ((a[1:0] != 2'b00) || ((a >> 2) >= 32'd10000)) return NOP;
    return img[a[7:2]];
  endfunction

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    vec_t v;
    logic [31:0] e;

    // row: ld_req ld_addr ld_data done if_req if_addr | ld_gnt if_gnt we maddr state halted fault cnt
    vecs[0]  = mk(1, 0,  W0,   0, 1, 0,     1, 0, 1, 0,     S_LOAD, 0, 0, 0);
    vecs[1]  = mk(1, 4,  W1,   0, 0, 0,     1, 0, 1, 1,     S_LOAD, 0, 0, 0);
    vecs[2]  = mk(1, 8,  W2,   0, 0, 0,     1, 0, 1, 2,     S_LOAD, 0, 0, 0);
    vecs[3]  = mk(1, 12, HALT, 1, 0, 0,     1, 0, 1, 3,     S_LOAD, 0, 0, 0);
    vecs[4]  = mk(0, 0,  0,    0, 0, 0,     0, 0, 0, 0,     S_RUN,  0, 0, 0);
    vecs[5]  = mk(0, 0,  0,    0, 1, 8,     0, 1, 0, 2,     S_RUN,  0, 0, 0);
    vecs[6]  = mk(0, 0,  0,    0, 0, 0,     0, 0, 0, 0,     S_RUN,  0, 0, 1);
    vecs[7]  = mk(1, 16, 32'hCAFE0005, 0, 1, 4, 1, 0, 1, 4, S_RUN,  0, 0, 1);
    vecs[8]  = mk(0, 0,  0,    0, 1, 16,    0, 1, 0, 4,     S_RUN,  0, 0, 1);
    vecs[9]  = mk(0, 0,  0,    0, 1, 6,     0, 1, 0, 1,     S_RUN,  0, 0, 2);
    vecs[10] = mk(0, 0,  0,    0, 1, 40000, 0, 1, 0, 10000, S_RUN,  0, 1, 3);
    vecs[11] = mk(0, 0,  0,    1, 0, 0,     0, 0, 0, 0,     S_RUN,  0, 1, 4);
    vecs[12] = mk(0, 0,  0,    0, 1, 0,     0, 1, 0, 0,     S_RUN,  0, 1, 4);
    vecs[13] = mk(0, 0,  0,    0, 1, 12,    0, 1, 0, 3,     S_RUN,  0, 1, 5);
    vecs[14] = mk(0, 0,  0,    0, 1, 4,     0, 1, 0, 1,     S_RUN,  0, 1, 6);
    vecs[15] = mk(1, 20, 32'h0BAD0BAD, 0, 1, 8, 0, 0, 0, 0, S_HALT, 1, 1, 7);
    vecs[16] = mk(0, 0,  0,    1, 1, 8,     0, 0, 0, 0,     S_HALT, 1, 1, 7);

    // Asynchronous reset takes effect before any clock edge.
    #3;
    chk("rst_state", 32'(state), 32'(S_LOAD));
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_fetch_cnt", 32'(fetch_cnt), 0);

    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      ld_req = v.ld_req; ld_addr = v.ld_addr; ld_data = v.ld_data; ld_done = v.ld_done;
      if_req = v.if_req; if_addr = v.if_addr;
      #1;
      chk($sformatf("v%0d_ld_gnt", i), 32'(ld_gnt), 32'(v.e_ld_gnt));
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(v.e_if_gnt));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.e_we));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v.e_maddr);
      if (v.e_we) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, v.ld_data);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(v.e_state));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v.e_halted));
      chk($sformatf("v%0d_fault", i), 32'(fault), 32'(v.e_fault));
      chk($sformatf("v%0d_fetch_cnt", i), 32'(fetch_cnt), 32'(v.e_cnt));
      chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (if_valid) chk($sformatf("v%0d_if_inst", i), if_inst, e);
      end
      if (v.e_if_gnt) exp_q.push_back(expect_inst(v.if_addr));
      if (v.e_we) img[v.ld_addr[7:2]] = v.ld_data;
      @(posedge clk); #1;
    end
    ld_req = 0; ld_done = 0; if_req = 0; ld_addr = 0; if_addr = 0;

    // Reset while halted clears everything at once.
    #2 reset = 1'b1;
    #1;
    chk("halt_rst_state", 32'(state), 32'(S_LOAD));
    chk("halt_rst_halted", 32'(halted), 0);
    chk("halt_rst_fault", 32'(fault), 0);
    chk("halt_rst_fetch_cnt", 32'(fetch_cnt), 0);
    chk("halt_rst_if_valid", 32'(if_valid), 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;

    // First edge after release follows LOAD rules.
    ld_done = 1'b1;
    @(posedge clk); #1 ld_done = 1'b0;
    chk("reload_state", 32'(state), 32'(S_RUN));

    // Reset asserted with a grant outstanding: the read must never surface.
    if_req = 1'b1; if_addr = 32'd4;
    #1 chk("inflight_if_gnt", 32'(if_gnt), 1);
    #2 reset = 1'b1;
    if_req = 1'b0;
    #1 chk("inflight_rst_if_valid", 32'(if_valid), 0);
    @(posedge clk); #1 reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_rst%0d_if_valid", k), 32'(if_valid), 0);
      chk($sformatf("post_rst%0d_state", k), 32'(state), 32'(S_LOAD));
      @(posedge clk); #1;
    end

    // Saturation of the delivered-instruction counter.
    ld_done = 1'b1;
    @(posedge clk); #1 ld_done = 1'b0;
    if_req = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      if_addr = 32'($urandom_range(0, 2)) << 2;
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    chk("sat_fetch_cnt", 32'(fetch_cnt), 32'hFFFF);
    chk("sat_if_valid", 32'(if_valid), 1);
    chk("sat_fault", 32'(fault), 0);
    chk("sat_state", 32'(state), 32'(S_RUN));
    @(posedge clk); #1;
    chk("sat_hold_fetch_cnt", 32'(fetch_cnt), 32'hFFFF);
    chk("sat_idle_if_valid", 32'(if_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
